instruction_store: RTL and testbench
====================================

# instruction_store

Parametrised instruction memory with a hardware clear sequencer, a program-load write port and a pipelined fetch port with valid/ready handshaking. It replaces the fixed 4096×19 asynchronous-read store. It sits between the loader/testbench and the fetch stage and delivers one instruction per cycle at full throughput once cleared.

## Interface
- `DATA_W`, default 19: instruction width in bits.
- `ADDR_W`, default 12: address width.
- `DEPTH`, default 4096: number of words, must satisfy `DEPTH <= 2**ADDR_W`.

- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `busy` output 1: high while the clear sweep runs.
- `prog_we` input 1: program write strobe.
- `prog_addr` input ADDR_W: program write address.
- `prog_data` input DATA_W: program write data.
- `req_valid` input 1: fetch request valid.
- `req_addr` input ADDR_W: fetch address.
- `req_ready` output 1: fetch request accepted when high together with `req_valid`.
- `resp_valid` output 1: `resp_data` valid.
- `resp_data` output DATA_W: fetched instruction.
- `resp_err` output 1: qualifies the response; address was ≥ DEPTH, or there was a parity fault when parity is compiled in.
- `resp_ready` input 1: consumer accepts the response.

## Operation
- FSM states: CLEAR and RUN.
- `rst` sampled high sets the state to CLEAR and `clr_ptr` to 0, and clears `resp_valid`. This applies from any state and at any time, including mid-sweep or mid-fetch.
- CLEAR:
  - Writes zero to `mem[clr_ptr]` each cycle, then increments `clr_ptr`.
  - After writing `DEPTH-1`, the next state is RUN.
  - `busy`=1 and `req_ready`=0.
  - `prog_we` is ignored and the write is dropped.
- RUN:
  - `busy`=0.
  - `prog_we`=1 with `prog_addr` < DEPTH writes `mem[prog_addr]`. An out-of-range write is dropped.
  - `req_ready` = `!resp_valid || resp_ready`, which gives a single output register with stall.
  - A request accepted with address < DEPTH loads `resp_data` = `mem[req_addr]` and `resp_err`=0.
  - A request accepted with address ≥ DEPTH loads `resp_data`=0 and `resp_err`=1.
  - If the fetch and program write hit the same in-range address in the same cycle, the fetch returns the new `prog_data` (write-through bypass).
  - A held response (`resp_valid`=1, `resp_ready`=0) keeps `resp_data` and `resp_err` stable. A later `prog_we` to that address does not alter it.
  - A response consumed with no new accept clears `resp_valid`. Consume and accept in the same cycle replace the response, with no bubble.

## Timing
- Reset values: `busy`=1, `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_err`=0.
- The clear sweep takes exactly DEPTH cycles after the reset cycle. `req_ready` first rises in cycle DEPTH+1 after `rst` falls.
- Fetch latency is 1 cycle. A request accepted at edge N gives `resp_valid`=1 and the data after edge N.
- Throughput is 1 fetch/cycle while `resp_ready`=1.
- Program writes are visible to fetches accepted at the same edge (bypass) and at all later edges.
- `req_ready` is combinational from `resp_valid`, `resp_ready` and the FSM state only. There is no path from `req_valid`.

## Configuration
- `INSTRUCTION_STORE_PARITY_EN` defined:
  - Each word stores an extra even-parity bit, computed on program write; cleared words store parity 0.
  - On fetch the parity is recomputed. A mismatch sets `resp_err`=1, but `resp_data` is still the stored word.
  - Port widths are unchanged.
- Not defined: no parity storage or check, and `resp_err` reflects only out-of-range addresses.

## Test plan
- Reset with DEPTH=16: `busy`=1 for 16 cycles and `req_ready`=0. Afterwards, fetch every address 0–15: all return 0 with `resp_err`=0.
- Program `mem[1]`=19'h0A60 and `mem[10]`=19'h0B740, then issue back-to-back fetches 1,10,1 with `resp_ready`=1: responses 19'h0A60, 19'h0B740, 19'h0A60 on consecutive cycles, no bubbles.
- Hold `resp_ready`=0 for 3 cycles with a response pending: `req_ready`=0, and `resp_data` is stable even across a `prog_we` to the same address. Raise `resp_ready` and the next queued request is accepted in that cycle.
- Same-cycle `prog_we` to addr 5 with data 19'h12345 and fetch of addr 5: response 19'h12345.
- DEPTH=16, ADDR_W=12, fetch addr 20: `resp_data`=0 and `resp_err`=1. `prog_we` to addr 20 has no effect on any word.
- Assert `rst` mid-sweep at `clr_ptr`=7 after programming: the sweep restarts from 0 for the full DEPTH cycles. With `INSTRUCTION_STORE_PARITY_EN`, force a stored bit flip: `resp_err`=1 with the corrupted data returned.

Source files
------------

// File: rtl/instruction_store.sv
// Parametrised instruction memory: zeroing sweep after reset, program write port,
// 1-cycle fetch with a single stalling output register. Optional parity: INSTRUCTION_STORE_PARITY_EN.
module instruction_store #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  input  logic              resp_ready
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef INSTRUCTION_STORE_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  clr_ptr_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [MEM_W-1:0]  mem_q [DEPTH];

  logic              prog_hit;
  logic              req_hit;
  logic              accept;
  logic              bypass;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  rd_word;
  logic [DATA_W-1:0] rd_data_d;
  logic              rd_err_d;

  function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef INSTRUCTION_STORE_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign prog_hit  = prog_we && ({1'b0, prog_addr} < DEPTH_C);
  assign req_hit   = {1'b0, req_addr} < DEPTH_C;
  assign req_ready = (state_q == RUN) && (!resp_valid_q || resp_ready);
  assign accept    = req_valid && req_ready;
  assign bypass    = prog_hit && (prog_addr == req_addr);
  assign rd_word   = mem_q[req_addr[IDX_W-1:0]];

  // Fetch word selection: out-of-range -> error, same-cycle write -> forwarded data
  always_comb begin
    rd_data_d = '0;
    rd_err_d  = 1'b1;
    if (req_hit) begin
      if (bypass) begin
        rd_data_d = prog_data;
        rd_err_d  = 1'b0;
      end else begin
        rd_data_d = rd_word[DATA_W-1:0];
`ifdef INSTRUCTION_STORE_PARITY_EN
        rd_err_d  = (^rd_word[DATA_W-1:0]) != rd_word[DATA_W];
`else
        rd_err_d  = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = prog_addr[IDX_W-1:0];
    mem_wdata = encode(prog_data);
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
      end else if (prog_hit) begin
        mem_we    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Control FSM and response register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      clr_ptr_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LAST_IDX) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= rd_data_d;
            resp_err_q   <= rd_err_d;
          end else if (resp_ready) begin
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign busy       = (state_q == CLEAR);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_instruction_store.sv
// Self-checking bench for instruction_store (DEPTH=16): directed scenarios plus
// randomized traffic compared every cycle against a behavioural memory model.
module tb_instruction_store;

  localparam int DATA_W = 19;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              busy;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              resp_ready;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instruction_store #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .busy(busy),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .resp_ready(resp_ready)
  );

  // Behavioural model state
  logic [DATA_W-1:0] mm [DEPTH];
  bit                bad [DEPTH];
  int                clr_left = 0;
  bit                started = 1'b0;
  bit                exp_valid = 1'b0;
  bit                exp_err = 1'b0;
  logic [DATA_W-1:0] exp_data = '0;
  bit                data_known = 1'b0;
  bit                m_ready;
  bit                m_wr;
  int                pa;
  int                ra;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      started    = 1'b1;
      clr_left   = DEPTH;
      exp_valid  = 1'b0;
      exp_data   = '0;
      exp_err    = 1'b0;
      data_known = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mm[i]  = '0;
        bad[i] = 1'b0;
      end
    end else if (started) begin
      if (clr_left > 0) begin
        clr_left--;
      end else begin
        pa      = int'(prog_addr);
        ra      = int'(req_addr);
        m_ready = !exp_valid || resp_ready;
        m_wr    = prog_we && (pa < DEPTH);
        if (m_ready && req_valid) begin
          exp_valid  = 1'b1;
          data_known = 1'b0;
          if (ra < DEPTH) begin
            if (m_wr && pa == ra) begin
              exp_data = prog_data;
              exp_err  = 1'b0;
            end else begin
              exp_data = mm[req_addr[3:0]];
              exp_err  = bad[req_addr[3:0]];
            end
          end else begin
            exp_data = '0;
            exp_err  = 1'b1;
          end
        end else if (resp_ready) begin
          exp_valid = 1'b0;
        end
        if (m_wr) begin
          mm[prog_addr[3:0]]  = prog_data;
          bad[prog_addr[3:0]] = 1'b0;
        end
      end
    end
    #1;
    if (started) begin
      check("busy", busy, clr_left > 0);
      check("req_ready", req_ready, (clr_left == 0) && (!exp_valid || resp_ready));
      check("resp_valid", resp_valid, exp_valid);
      if (exp_valid || data_known) begin
        check("resp_data", resp_data, exp_data);
        check("resp_err", resp_err, exp_err);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    step();
    check("rst_busy", busy, 1);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", resp_err, 0);
    step();
    rst = 1'b0;
    repeat (DEPTH - 1) step();
    check("sweep_busy_last", busy, 1);
    step();
    check("sweep_done_busy", busy, 0);
    check("sweep_done_ready", req_ready, 1);

    // Fetch every word after the sweep
    for (int i = 0; i < DEPTH; i++) begin
      req_valid = 1'b1; req_addr = ADDR_W'(i);
      step();
    end
    check("cleared_word15", resp_data, 0);
    req_valid = 1'b0;

    prog_we = 1'b1; prog_addr = 12'd1;  prog_data = 19'h0A60;  step();
    prog_addr = 12'd10; prog_data = 19'h0B740; step();
    prog_we = 1'b0;
    req_valid = 1'b1; req_addr = 12'd1;  step();
    check("b2b_0", resp_data, 19'h0A60);
    req_addr = 12'd10; step();
    check("b2b_1", resp_data, 19'h0B740);
    req_addr = 12'd1;  step();
    check("b2b_2", resp_data, 19'h0A60);
    check("b2b_valid", resp_valid, 1);

    // Stall with a queued request and an overwrite of the held address
    req_addr = 12'd10; step();
    resp_ready = 1'b0; req_addr = 12'd1;
    prog_we = 1'b1; prog_addr = 12'd10; prog_data = 19'h00007;
    for (int k = 0; k < 3; k++) begin
      #1 check("stall_ready", req_ready, 0);
      step();
      prog_we = 1'b0;
      check("stall_hold", resp_data, 19'h0B740);
    end
    resp_ready = 1'b1;
    #1 check("unstall_ready", req_ready, 1);
    step();
    check("unstall_data", resp_data, 19'h0A60);
    req_valid = 1'b0; step();

    prog_we = 1'b1; prog_addr = 12'd5; prog_data = 19'h12345;
    req_valid = 1'b1; req_addr = 12'd5; step();
    check("bypass", resp_data, 19'h12345);
    prog_we = 1'b0;

    req_addr = 12'd20; step();
    check("oob_data", resp_data, 0);
    check("oob_err", resp_err, 1);
    req_valid = 1'b0;
    prog_we = 1'b1; prog_addr = 12'd20; prog_data = 19'h7FFFF; step();
    prog_we = 1'b0;
    req_valid = 1'b1; req_addr = 12'd4; step();
    check("oob_write_dropped", resp_data, 0);
    check("oob_write_err", resp_err, 0);
    req_valid = 1'b0; step();

    for (int n = 0; n < 600; n++) begin
      prog_we    = ($urandom_range(0, 3) == 0);
      prog_addr  = ADDR_W'($urandom_range(0, 19));
      prog_data  = DATA_W'($urandom);
      req_valid  = ($urandom_range(0, 3) != 0);
      req_addr   = ADDR_W'($urandom_range(0, 19));
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    prog_we = 1'b0; req_valid = 1'b0; resp_ready = 1'b1; step();

    // Reset mid-fetch, then again mid-sweep
    prog_we = 1'b1; prog_addr = 12'd3; prog_data = 19'h2AAAA; step();
    prog_we = 1'b0; req_valid = 1'b1; req_addr = 12'd3; step();
    req_valid = 1'b0;
    rst = 1'b1; step();
    rst = 1'b0;
    check("midfetch_rst_valid", resp_valid, 0);
    repeat (7) step();
    rst = 1'b1; step();
    rst = 1'b0;
    repeat (DEPTH - 1) step();
    check("restart_busy", busy, 1);
    step();
    check("restart_done", busy, 0);
    req_valid = 1'b1; req_addr = 12'd3; step();
    check("restart_cleared", resp_data, 0);
    req_valid = 1'b0; step();

`ifdef INSTRUCTION_STORE_PARITY_EN
    prog_we = 1'b1; prog_addr = 12'd2; prog_data = 19'h00005; step();
    prog_we = 1'b0;
    dut.mem_q[2][0] = ~dut.mem_q[2][0];
    mm[2][0] = ~mm[2][0];
    bad[2] = 1'b1;
    req_valid = 1'b1; req_addr = 12'd2; step();
    check("parity_data", resp_data, 19'h00004);
    check("parity_err", resp_err, 1);
    req_valid = 1'b0; step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
